b_resolver: RTL and testbench
=============================

# b_resolver

Branch resolution queue: the update-side companion of the branch predictor. Fetch pushes one entry per predicted branch (predictor tag plus predicted direction). Execute resolves branches in program order against the queue head. The block drives the predictor's training port (`we`, `tag_in`, `t_in`) and raises a one-cycle mispredict pulse that flushes the wrong-path entries.

## Interface
- `TAG_LEN`, 10, predictor tag width; must equal the predictor's `TAG_LEN`.
- `DEPTH`, 8, maximum number of in-flight branches; a power of two, at least 2.
- `PTR_W`, 3, pointer width, equal to log2(`DEPTH`).
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `push_valid`  in  1  fetch presents a predicted branch.
- `push_tag`  in  `TAG_LEN`  predictor tag of that branch.
- `push_pred`  in  1  predicted direction (the predictor's `t_out`).
- `push_ready`  out  1  queue can accept a push this cycle.
- `res_valid`  in  1  execute resolves the oldest in-flight branch.
- `res_taken`  in  1  actual direction.
- `flush`  in  1  external pipeline flush (exception, redirect).
- `upd_we`  out  1  one-cycle training strobe; drives the predictor's `we`.
- `upd_tag`  out  `TAG_LEN`  drives the predictor's `tag_in`.
- `upd_t`  out  1  drives the predictor's `t_in`.
- `mispredict`  out  1  one-cycle pulse when the resolved direction differs from the prediction.
- `res_err`  out  1  one-cycle pulse when `res_valid` arrives with the queue empty.
- `occupancy`  out  `PTR_W+1`  current entry count.

## Operation
- Storage: a circular buffer of `DEPTH` entries, each {tag, pred}, with head and tail pointers of `PTR_W` bits (wrapping modulo `DEPTH`) and a `PTR_W+1`-bit count.
- `push_ready` = (count != `DEPTH`). It is combinational from registered count only, with no dependence on `res_valid` in the same cycle.
- Push is accepted when `push_valid && push_ready`. On acceptance:
  - the entry is written at tail;
  - tail increments.
- Resolve when count > 0:
  - head entry is read and head increments;
  - the next cycle drives `upd_we`=1, `upd_tag`=entry tag, `upd_t`=`res_taken`, and `mispredict`=(`res_taken` != entry pred).
- Resolve when count = 0: no pop, no update; `res_err`=1 for one cycle.
- Mispredict recovery:
  - the cycle the mismatching resolve is accepted, every younger entry is wrong-path, so the queue empties (count=0, tail=new head);
  - a push in that same cycle is discarded.
- `flush` empties the queue identically. A resolve in the same cycle as `flush` still pops, trains and reports normally, then the queue empties. A push in that cycle is discarded.
- Simultaneous push and resolve (no mispredict, no flush): both take effect and count is unchanged. When full, the push is refused because `push_ready`=0.
- Reset: count=0, head=tail=0.
  - Outputs after reset: `push_ready`=1, `upd_we`=0, `upd_tag`=0, `upd_t`=0, `mispredict`=0, `res_err`=0, `occupancy`=0.
  - A reset mid-operation discards all entries and any pending update output.

## Timing
- Push to visibility: an entry pushed in cycle N can be resolved from cycle N+1.
- Resolve latency: `res_valid` in cycle N gives `upd_we`/`mispredict` high in N+1 only. Back-to-back resolves give back-to-back strobes.
- `upd_tag`/`upd_t` hold their last value while `upd_we`=0.
- `occupancy` and `push_ready` reflect register state after edge N when sampled in cycle N+1.
- Throughput: one push and one resolve per cycle.

## Configuration
- `B_RESOLVER_STATS_EN` defined adds two 32-bit output ports:
  - `stat_branches` counts successful resolves;
  - `stat_mispred` counts mispredict pulses.
- Both counters update in the same cycle as `upd_we`, wrap at 2^32, and are cleared by `rst` only (not by `flush`).
- `B_RESOLVER_STATS_EN` undefined: the ports and counters do not exist, and all other behaviour is identical.

## Test plan
- Reset, then push tags 0x005(pred 1), 0x00A(pred 0) and resolve taken=1, taken=0 -> `upd_we` pulses two consecutive cycles with (0x005,1), (0x00A,0), `mispredict`=0, `occupancy` 2->0.
- Fill 8 entries -> `push_ready`=0, a ninth push is ignored; push plus resolve in one cycle while full -> only the pop occurs and `occupancy`=7.
- Push 4 entries, resolve the head with the opposite direction while pushing -> `mispredict`=1 one cycle, `upd_tag`=head tag, `occupancy`=0, the same-cycle push is lost.
- `res_valid` with an empty queue -> `res_err`=1 one cycle, `upd_we`=0; `flush` with 5 entries -> `occupancy`=0 next cycle, no `upd_we`.
- Wrap-around: 20 push/resolve pairs at depth 8 -> the tag order of `upd_tag` matches the push order exactly.
- With `B_RESOLVER_STATS_EN`: 10 resolves including 3 mismatches -> `stat_branches`=10, `stat_mispred`=3; a `rst` asserted mid-stream zeroes both counters and all outputs on the next edge.

Source files
------------

// File: rtl/b_resolver.sv
// b_resolver -- branch resolution queue.
//
// Update-side companion of the branch predictor. Fetch pushes one entry
// ({tag, predicted direction}) per predicted branch; execute resolves
// branches in program order against the queue head. Each accepted resolve
// produces a one-cycle training strobe for the predictor on the following
// cycle, plus a mispredict pulse when the actual direction differs from the
// prediction. A mispredict or an external flush discards all younger
// (wrong-path) entries.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   push_valid/tag/pred      fetch push of a predicted branch
//   push_ready               queue not full (from registered count only)
//   res_valid, res_taken     execute resolves the oldest branch
//   flush                    external pipeline flush
//   upd_we/upd_tag/upd_t     predictor training port (we, tag_in, t_in)
//   mispredict               one-cycle pulse on direction mismatch
//   res_err                  one-cycle pulse on resolve with empty queue
//   occupancy                current entry count
//
// Optional feature: define B_RESOLVER_STATS_EN to add the 32-bit
// stat_branches / stat_mispred counters (cleared by rst only).

module b_resolver #(
  parameter int TAG_LEN = 10,
  parameter int DEPTH   = 8,
  parameter int PTR_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_valid,
  input  logic [TAG_LEN-1:0] push_tag,
  input  logic               push_pred,
  output logic               push_ready,
  input  logic               res_valid,
  input  logic               res_taken,
  input  logic               flush,
  output logic               upd_we,
  output logic [TAG_LEN-1:0] upd_tag,
  output logic               upd_t,
  output logic               mispredict,
  output logic               res_err,
`ifdef B_RESOLVER_STATS_EN
  output logic [31:0]        stat_branches,
  output logic [31:0]        stat_mispred,
`endif
  output logic [PTR_W:0]     occupancy
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  // Entry storage (data only, never reset; validity is tracked by count)
  logic [TAG_LEN-1:0] tag_mem_q  [DEPTH];
  logic               pred_mem_q [DEPTH];

  // Control state
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [PTR_W:0]     count_q, count_d;

  // Registered training / status outputs
  logic               upd_we_q, upd_we_d;
  logic [TAG_LEN-1:0] upd_tag_q, upd_tag_d;
  logic               upd_t_q, upd_t_d;
  logic               mispredict_q, mispredict_d;
  logic               res_err_q, res_err_d;

  // Decode of this cycle's requests
  logic               push_acc;
  logic               res_ok;
  logic               mis;
  logic               clear;
  logic               wr_en;
  logic [TAG_LEN-1:0] head_tag;
  logic               head_pred;

  assign push_ready = (count_q != FULL_CNT);
  assign head_tag   = tag_mem_q[head_q];
  assign head_pred  = pred_mem_q[head_q];

  always_comb begin
    push_acc = push_valid && push_ready;
    res_ok   = res_valid && (count_q != '0);
    mis      = res_ok && (res_taken != head_pred);
    // Everything behind a mispredicted head is wrong-path; a flush likewise
    // kills every remaining entry. The head pop itself still happens first.
    clear    = mis || flush;
    wr_en    = push_acc && !clear;
  end

  // ---- Stage 0: queue pointer / count update ----
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (res_ok) begin
      head_d = head_q + 1'b1;
    end

    if (clear) begin
      tail_d  = head_d;
      count_d = '0;
    end else begin
      if (push_acc) begin
        tail_d = tail_q + 1'b1;
      end
      count_d = count_q + (PTR_W+1)'(push_acc) - (PTR_W+1)'(res_ok);
    end
  end

  always_comb begin
    upd_we_d     = res_ok;
    upd_tag_d    = upd_tag_q;
    upd_t_d      = upd_t_q;
    mispredict_d = mis;
    res_err_d    = res_valid && (count_q == '0);
    if (res_ok) begin
      upd_tag_d = head_tag;
      upd_t_d   = res_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem_q[tail_q]  <= push_tag;
      pred_mem_q[tail_q] <= push_pred;
    end
  end

  // ---- Stage 1: registered training outputs ----
  // upd_tag/upd_t are part of the observable post-reset state, so they are
  // reset along with the control flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      upd_we_q     <= 1'b0;
      upd_tag_q    <= '0;
      upd_t_q      <= 1'b0;
      mispredict_q <= 1'b0;
      res_err_q    <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      upd_we_q     <= upd_we_d;
      upd_tag_q    <= upd_tag_d;
      upd_t_q      <= upd_t_d;
      mispredict_q <= mispredict_d;
      res_err_q    <= res_err_d;
    end
  end

  assign upd_we     = upd_we_q;
  assign upd_tag    = upd_tag_q;
  assign upd_t      = upd_t_q;
  assign mispredict = mispredict_q;
  assign res_err    = res_err_q;
  assign occupancy  = count_q;

`ifdef B_RESOLVER_STATS_EN
  // Counters advance from the same decode as upd_we/mispredict so that the
  // new value becomes visible in the same cycle as the strobe.
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispred_q, stat_mispred_d;

  always_comb begin
    stat_branches_d = stat_branches_q + 32'(res_ok);
    stat_mispred_d  = stat_mispred_q + 32'(mis);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_mispred  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_b_resolver.sv
module tb_b_resolver;

  localparam int TAG_LEN = 10;
  localparam int DEPTH   = 8;
  localparam int PTR_W   = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               push_valid;
  logic [TAG_LEN-1:0] push_tag;
  logic               push_pred;
  logic               push_ready;
  logic               res_valid;
  logic               res_taken;
  logic               flush;
  logic               upd_we;
  logic [TAG_LEN-1:0] upd_tag;
  logic               upd_t;
  logic               mispredict;
  logic               res_err;
  logic [PTR_W:0]     occupancy;
`ifdef B_RESOLVER_STATS_EN
  logic [31:0]        stat_branches;
  logic [31:0]        stat_mispred;
`endif

  b_resolver #(.TAG_LEN(TAG_LEN), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_tag(push_tag), .push_pred(push_pred),
    .push_ready(push_ready),
    .res_valid(res_valid), .res_taken(res_taken), .flush(flush),
    .upd_we(upd_we), .upd_tag(upd_tag), .upd_t(upd_t),
    .mispredict(mispredict), .res_err(res_err),
`ifdef B_RESOLVER_STATS_EN
    .stat_branches(stat_branches), .stat_mispred(stat_mispred),
`endif
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Reference model: in-order list of in-flight branches
  typedef struct packed {
    logic [TAG_LEN-1:0] tag;
    logic               pred;
  } ent_t;

  ent_t q[$];
  logic               e_we, e_t, e_mis, e_err;
  logic [TAG_LEN-1:0] e_tag;
  int unsigned        e_br, e_mp;
  int                 n_checks = 0;
  int                 n_fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, check all outputs after the edge.
  task automatic step(input logic pv, input logic [TAG_LEN-1:0] pt, input logic pp,
                      input logic rv, input logic rt, input logic fl, input logic r);
    bit   can_push;
    ent_t e;
    bit   clr;
    push_valid = pv; push_tag = pt; push_pred = pp;
    res_valid  = rv; res_taken = rt; flush = fl; rst = r;
    if (!r) chk("push_ready_pre", 32'(push_ready), 32'(q.size() != DEPTH));
    @(posedge clk);
    if (r) begin
      q.delete();
      e_we = 0; e_t = 0; e_mis = 0; e_err = 0; e_tag = '0; e_br = 0; e_mp = 0;
    end else begin
      can_push = pv && (q.size() < DEPTH);
      e_we = 0; e_mis = 0; e_err = 0;
      if (rv) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          e_we = 1; e_tag = e.tag; e_t = rt; e_mis = (rt != e.pred);
          e_br++;
          if (e_mis) e_mp++;
        end else begin
          e_err = 1;
        end
      end
      clr = e_mis || fl;
      if (clr) q.delete();
      else if (can_push) q.push_back('{tag: pt, pred: pp});
    end
    #1;
    chk("upd_we", 32'(upd_we), 32'(e_we));
    chk("upd_tag", 32'(upd_tag), 32'(e_tag));
    chk("upd_t", 32'(upd_t), 32'(e_t));
    chk("mispredict", 32'(mispredict), 32'(e_mis));
    chk("res_err", 32'(res_err), 32'(e_err));
    chk("occupancy", 32'(occupancy), 32'(q.size()));
    chk("push_ready", 32'(push_ready), 32'(q.size() != DEPTH));
`ifdef B_RESOLVER_STATS_EN
    chk("stat_branches", stat_branches, e_br);
    chk("stat_mispred", stat_mispred, e_mp);
`endif
  endtask

  function automatic logic head_pred();
    return (q.size() > 0) ? q[0].pred : 1'b0;
  endfunction

  initial begin
    push_valid = 0; push_tag = '0; push_pred = 0;
    res_valid = 0; res_taken = 0; flush = 0; rst = 1;
    e_we = 0; e_t = 0; e_mis = 0; e_err = 0; e_tag = '0; e_br = 0; e_mp = 0;

    // Reset state
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);

    // Two pushes, two correct resolves -> back-to-back strobes
    step(1, 10'h005, 1, 0, 0, 0, 0);
    step(1, 10'h00A, 0, 0, 0, 0, 0);
    chk("occ_two", 32'(occupancy), 32'd2);
    step(0, 0, 0, 1, 1, 0, 0);
    chk("first_tag", 32'(upd_tag), 32'h005);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("second_tag", 32'(upd_tag), 32'h00A);
    step(0, 0, 0, 0, 0, 0, 0);

    // Fill, ninth push refused, push+resolve while full pops only
    for (int i = 0; i < DEPTH; i++) step(1, 10'(16 + i), 1'(i), 0, 0, 0, 0);
    chk("full_ready", 32'(push_ready), 32'd0);
    step(1, 10'h3FF, 1, 0, 0, 0, 0);
    step(1, 10'h3FE, 1, 1, head_pred(), 0, 0);
    chk("full_pop_occ", 32'(occupancy), 32'd7);
    step(0, 0, 0, 0, 0, 1, 0);

    // Mispredict with a same-cycle push
    for (int i = 0; i < 4; i++) step(1, 10'(32 + i), 1, 0, 0, 0, 0);
    step(1, 10'h111, 0, 1, ~head_pred(), 0, 0);
    chk("mis_tag", 32'(upd_tag), 32'd32);
    chk("mis_occ", 32'(occupancy), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Resolve on empty; flush with 5 entries; resolve+flush together
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 10'(48 + i), 0, 0, 0, 0, 0);
    step(1, 10'h222, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 10'(64 + i), 1, 0, 0, 0, 0);
    step(1, 10'h333, 0, 1, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Wrap-around: 20 push/resolve pairs through the 8-deep ring
    step(1, 10'h100, 0, 0, 0, 0, 0);
    for (int i = 1; i < 20; i++) step(1, 10'(10'h100 + i), 1'(i), 1, head_pred(), 0, 0);
    step(0, 0, 0, 1, head_pred(), 0, 0);
    chk("wrap_last_tag", 32'(upd_tag), 32'h113);

    // Stats: 10 resolves with exactly 3 mismatches, then mid-stream reset
    step(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(1, 10'(200 + i), 1'(i), 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      // mismatches flush the queue, so refill one entry before each later resolve
      if (q.size() == 0) step(1, 10'(300 + i), 1'(i), 0, 0, 0, 0);
      step(0, 0, 0, 1, (i == 9 || i == 6 || i == 3) ? ~head_pred() : head_pred(), 0, 0);
    end
`ifdef B_RESOLVER_STATS_EN
    chk("stat_br10", stat_branches, 32'd10);
    chk("stat_mp3", stat_mispred, 32'd3);
`endif
    step(1, 10'h044, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 1);
    chk("rst_occ", 32'(occupancy), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic rv, rt;
      rv = ($urandom_range(0, 9) < 5);
      rt = ($urandom_range(0, 9) < 8) ? head_pred() : ~head_pred();
      step(($urandom_range(0, 9) < 6), 10'($urandom), 1'($urandom), rv, rt,
           ($urandom_range(0, 49) == 0), ($urandom_range(0, 199) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
